// File: rtl/unified_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_sync
// Brief    : Unified byte-addressed memory with one fetch port, two read ports,
//            one byte-enabled write port, registered reads and a clear sequencer.
//            Optional misalignment check enabled by macro UMEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_sync #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 65536,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                if_en,
    input  logic [ADDR_W-1:0]   PC,
    output logic [DATA_W-1:0]   instruction,
    output logic                if_valid,
    input  logic                rd1_en,
    input  logic [ADDR_W-1:0]   address1,
    output logic [DATA_W-1:0]   data1,
    output logic                rd1_valid,
    input  logic                rd2_en,
    input  logic [ADDR_W-1:0]   address2,
    output logic [DATA_W-1:0]   data2,
    output logic                rd2_valid,
    input  logic                write,
    input  logic [ADDR_W-1:0]   dest_address,
    input  logic [DATA_W-1:0]   dest_data,
    input  logic [DATA_W/8-1:0] dest_be,
    output logic                align_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;

    localparam logic [0:0] S_READY = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [7:0]                   r_mem [DEPTH];
    logic [0:0]                   r_state;
    logic [0:0]                   w_state_next;
    logic [CNT_W-1:0]             r_clr_base;
    logic [CNT_W-1:0]             w_clr_base_next;
    logic                         w_ready;
    logic                         w_clearing;
    logic                         w_clr_last;
    logic                         w_wr_mis;
    logic                         w_wr_ok;
    logic [NB-1:0]                w_wr_be;
    logic [NB-1:0][IDX_W-1:0]     w_wr_idx;
    logic [2:0][ADDR_W-1:0]       w_rd_addr;
    logic [2:0]                   w_rd_acc;
    logic [2:0][DATA_W-1:0]       w_word;
    logic [2:0][DATA_W-1:0]       r_data;
    logic [2:0]                   r_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR_ON_RST ? S_CLEAR : S_READY;
            r_clr_base <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_base <= w_clr_base_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next    = r_state;
        w_clr_base_next = r_clr_base;
        case (r_state)
            S_READY: begin
                if (clr_req) begin
                    w_state_next    = S_CLEAR;
                    w_clr_base_next = '0;
                end
            end
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_state_next    = S_READY;
                    w_clr_base_next = '0;
                end else begin
                    w_clr_base_next = r_clr_base + CNT_W'(NB);
                end
            end
            default: w_state_next = S_READY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (r_state == S_CLEAR);
        w_clearing = (r_state == S_CLEAR) && !rst;
        w_ready    = (r_state == S_READY) && !rst;
        w_clr_last = (32'(r_clr_base) + 32'(NB)) >= 32'(DEPTH);
    end

    assign w_rd_addr = {address2, address1, PC};
    assign w_rd_acc  = {rd2_en && w_ready, rd1_en && w_ready, if_en && w_ready};
    assign w_wr_ok   = write && w_ready && !w_wr_mis;

    always_comb begin
        w_wr_be  = '0;
        w_wr_idx = '0;
        for (int k = 0; k < NB; k++) begin
            w_wr_be[k]  = w_wr_ok && dest_be[k];
            w_wr_idx[k] = dest_address[IDX_W-1:0] + IDX_W'(k);
        end
    end

    // Read words are assembled byte by byte so same-edge writes forward per byte
    always_comb begin
        logic [IDX_W-1:0] ri;
        ri     = '0;
        w_word = '0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < NB; j++) begin
                ri = w_rd_addr[p][IDX_W-1:0] + IDX_W'(j);
                w_word[p][8*j +: 8] = r_mem[ri];
                for (int k = 0; k < NB; k++) begin
                    if (w_wr_be[k] && (w_wr_idx[k] == ri)) begin
                        w_word[p][8*j +: 8] = dest_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clearing) begin
            for (int i = 0; i < NB; i++) begin
                if ((32'(r_clr_base) + 32'(i)) < 32'(DEPTH)) begin
                    r_mem[r_clr_base[IDX_W-1:0] + IDX_W'(i)] <= 8'h00;
                end
            end
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (w_wr_be[k]) begin
                    r_mem[w_wr_idx[k]] <= dest_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= w_rd_acc;
            for (int p = 0; p < 3; p++) begin
                if (w_rd_acc[p]) begin
                    r_data[p] <= w_word[p];
                end
            end
        end
    end

    assign instruction = r_data[0];
    assign data1       = r_data[1];
    assign data2       = r_data[2];
    assign if_valid    = r_valid[0];
    assign rd1_valid   = r_valid[1];
    assign rd2_valid   = r_valid[2];

`ifdef UMEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [ADDR_W-1:0] a);
        return (32'(a) % 32'(NB)) != 32'd0;
    endfunction

    logic r_align_err;
    logic w_align_hit;

    assign w_wr_mis    = misaligned(dest_address);
    assign w_align_hit = (write && w_ready && w_wr_mis) ||
                         (|(w_rd_acc & {misaligned(address2), misaligned(address1), misaligned(PC)}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_align_hit;
        end
    end

    assign align_err = r_align_err;
`else
    assign w_wr_mis  = 1'b0;
    assign align_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_sync
// Brief    : Directed plus random test of unified_mem_sync against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_sync;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 16;
    localparam int NB      = DATA_W / 8;
    localparam int CLR_CYC = DEPTH / NB;
`ifdef UMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, clr_req, busy;
    logic              if_en, if_valid, rd1_en, rd1_valid, rd2_en, rd2_valid;
    logic              write, align_err;
    logic [ADDR_W-1:0] PC, address1, address2, dest_address;
    logic [DATA_W-1:0] instruction, data1, data2, dest_data;
    logic [NB-1:0]     dest_be;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl_mem [DEPTH];
    logic [15:0] mdl_data [3];
    int          busy_left = 0;

    unified_mem_sync #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RST(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .if_en(if_en), .PC(PC), .instruction(instruction), .if_valid(if_valid),
        .rd1_en(rd1_en), .address1(address1), .data1(data1), .rd1_valid(rd1_valid),
        .rd2_en(rd2_en), .address2(address2), .data2(data2), .rd2_valid(rd2_valid),
        .write(write), .dest_address(dest_address), .dest_data(dest_data),
        .dest_be(dest_be), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Word at byte address a, with bytes being written this edge taking priority
    function automatic logic [15:0] mdl_word(input logic [15:0] a, input logic wr_on);
        logic [15:0] w;
        int          idx;
        logic [7:0]  b;
        w = '0;
        for (int j = 0; j < NB; j++) begin
            idx = (int'(a) + j) % DEPTH;
            b   = mdl_mem[idx];
            for (int k = 0; k < NB; k++) begin
                if (wr_on && dest_be[k] && ((int'(dest_address) + k) % DEPTH) == idx)
                    b = dest_data[8*k +: 8];
            end
            w[8*j +: 8] = b;
        end
        return w;
    endfunction

    task automatic idle();
        rst = 0; clr_req = 0; if_en = 0; rd1_en = 0; rd2_en = 0; write = 0;
        PC = '0; address1 = '0; address2 = '0;
        dest_address = '0; dest_data = '0; dest_be = '0;
    endtask

    task automatic zero_mem();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    endtask

    task automatic cycle();
        logic [15:0] addr [3];
        logic        en [3];
        logic        exp_v [3];
        logic        exp_err, wr_on, ready, wr_mis;
        addr    = '{PC, address1, address2};
        en      = '{if_en, rd1_en, rd2_en};
        ready   = (busy_left == 0) && !rst;
        wr_mis  = ALIGN_ON && ((int'(dest_address) % NB) != 0);
        wr_on   = ready && write && !wr_mis;
        exp_err = ready && write && wr_mis;
        for (int p = 0; p < 3; p++) begin
            exp_v[p] = ready && en[p];
            if (rst) mdl_data[p] = '0;
            else if (exp_v[p]) begin
                mdl_data[p] = mdl_word(addr[p], wr_on);
                if (ALIGN_ON && (int'(addr[p]) % NB) != 0) exp_err = 1'b1;
            end
        end
        @(posedge clk);
        if (rst) begin
            busy_left = CLR_CYC;
            zero_mem();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int k = 0; k < NB; k++)
                if (wr_on && dest_be[k]) mdl_mem[(int'(dest_address) + k) % DEPTH] = dest_data[8*k +: 8];
            if (clr_req) begin
                busy_left = CLR_CYC;
                zero_mem();
            end
        end
        #1;
        check("busy",        32'(busy),        32'(busy_left > 0));
        check("if_valid",    32'(if_valid),    32'(exp_v[0]));
        check("rd1_valid",   32'(rd1_valid),   32'(exp_v[1]));
        check("rd2_valid",   32'(rd2_valid),   32'(exp_v[2]));
        check("instruction", 32'(instruction), 32'(mdl_data[0]));
        check("data1",       32'(data1),       32'(mdl_data[1]));
        check("data2",       32'(data2),       32'(mdl_data[2]));
        check("align_err",   32'(align_err),   32'(exp_err));
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (busy && n < 20) begin
            cycle();
            n++;
        end
        check("busy_len", 32'(n), 32'(CLR_CYC));
    endtask

    initial begin
        zero_mem();
        mdl_data = '{16'h0, 16'h0, 16'h0};
        idle();
        #2;
        rst = 1; cycle(); rst = 0;
        check("rst_busy", 32'(busy), 32'd1);
        wait_clear();

        rd1_en = 1; address1 = 16'h0; cycle(); idle();
        check("t1_data1", 32'(data1), 32'h0000);

        write = 1; dest_address = 16'h4; dest_data = 16'hBEEF; dest_be = 2'b11; cycle(); idle();
        rd1_en = 1; address1 = 16'h4; rd2_en = 1; address2 = 16'h5; cycle(); idle();
        check("t2_data1", 32'(data1), 32'hBEEF);
        check("t2_data2", 32'(data2), 32'h00BE);

        write = 1; dest_address = 16'h4; dest_data = 16'h1234; dest_be = 2'b01; cycle(); idle();
        if_en = 1; PC = 16'h4; cycle(); idle();
        check("t3_instr", 32'(instruction), 32'hBE34);

        write = 1; dest_address = 16'h8; dest_data = 16'hA5A5; dest_be = 2'b11;
        rd1_en = 1; address1 = 16'h8; rd2_en = 1; address2 = 16'h7; cycle(); idle();
        check("t4_data1", 32'(data1), 32'hA5A5);
        check("t4_data2", 32'(data2), 32'hA500);

        write = 1; dest_address = 16'hF; dest_data = 16'hCAFE; dest_be = 2'b11; cycle(); idle();
        rd1_en = 1; address1 = 16'h0; cycle(); idle();
`ifndef UMEM_ALIGN_CHECK_EN
        check("t5_wrap", 32'(data1), 32'h00CA);
`endif
        clr_req = 1; cycle(); idle();
        wait_clear();
        rd1_en = 1; address1 = 16'hF; cycle(); idle();
        check("t5_cleared", 32'(data1), 32'h0000);

`ifdef UMEM_ALIGN_CHECK_EN
        write = 1; dest_address = 16'h3; dest_data = 16'h5555; dest_be = 2'b11; cycle(); idle();
        check("t6_wr_err", 32'(align_err), 32'd1);
        rd1_en = 1; address1 = 16'h2; cycle(); idle();
        check("t6_rd2_data", 32'(data1), 32'h0000);
        check("t6_rd2_err", 32'(align_err), 32'd0);
        rd1_en = 1; address1 = 16'h3; cycle(); idle();
        check("t6_rd3_err", 32'(align_err), 32'd1);
        check("t6_rd3_valid", 32'(rd1_valid), 32'd1);
`endif

        for (int i = 0; i < 500; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            clr_req      = ($urandom_range(0, 59) == 0);
            if_en        = $urandom_range(0, 1) == 1;
            rd1_en       = $urandom_range(0, 1) == 1;
            rd2_en       = $urandom_range(0, 1) == 1;
            write        = $urandom_range(0, 2) != 0;
            PC           = 16'($urandom);
            address1     = 16'($urandom);
            address2     = 16'($urandom);
            dest_address = 16'($urandom);
            dest_data    = 16'($urandom);
            dest_be      = 2'($urandom);
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
